// File: rtl/coastalwhite_canright_sbox_pkg.sv
// Shared constants and tower-field arithmetic for the Canright S-box.
// The inverse-direction layers exist only when CANRIGHT_INVERSE_EN is defined.
package coastalwhite_canright_sbox_pkg;

    localparam int unsigned CTRL_DIR_BIT  = 0;
    localparam int unsigned CTRL_LOAD_BIT = 1;

    localparam logic [7:0] AFFINE_C = 8'h63;

    // Normal bases: GF(4) over [W^2, W], GF(16) over [Z^4, Z], GF(256) over [Y^16, Y].
    // N = W^2 and nu = W^2 * Z^4 both have trace 1, so each quadratic extension is irreducible.
    localparam logic [1:0] GF4_N     = 2'b10;
    localparam logic [3:0] GF16_NU   = 4'b1000;
    localparam logic [7:0] GF256_ONE = 8'hFF;

    // 8x8 GF(2) matrix; column k occupies bits [8k+7:8k].
    typedef logic [63:0] mat_t;

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

    // Inversion in GF(4) is squaring, which swaps normal-basis coordinates.
    function automatic logic [1:0] gf4_inv(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] e;
        e = gf4_mul(gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]), GF4_N);
        return {gf4_mul(a[3:2], b[3:2]) ^ e, gf4_mul(a[1:0], b[1:0]) ^ e};
    endfunction

    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [1:0] s;
        logic [1:0] t;
        logic [1:0] d;
        s = a[3:2] ^ a[1:0];
        t = gf4_mul(a[3:2], a[1:0]) ^ gf4_mul(gf4_mul(s, s), GF4_N);
        d = gf4_inv(t);
        return {gf4_mul(d, a[1:0]), gf4_mul(d, a[3:2])};
    endfunction

    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] e;
        e = gf16_mul(gf16_mul(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]), GF16_NU);
        return {gf16_mul(a[7:4], b[7:4]) ^ e, gf16_mul(a[3:0], b[3:0]) ^ e};
    endfunction

    // (a*Y^16 + b*Y)^-1 = d*b*Y^16 + d*a*Y with d = (a*b + (a+b)^2*nu)^-1; maps 0 to 0.
    function automatic logic [7:0] gf256_inv(input logic [7:0] a);
        logic [3:0] s;
        logic [3:0] t;
        logic [3:0] d;
        s = a[7:4] ^ a[3:0];
        t = gf16_mul(a[7:4], a[3:0]) ^ gf16_mul(gf16_mul(s, s), GF16_NU);
        d = gf16_inv(t);
        return {gf16_mul(d, a[3:0]), gf16_mul(d, a[7:4])};
    endfunction

    function automatic logic [7:0] mat_apply(input mat_t m, input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (x[k]) r ^= m[8*k +: 8];
        end
        return r;
    endfunction

    // Returns a composed with b (b applied first).
    function automatic mat_t mat_compose(input mat_t a, input mat_t b);
        mat_t r;
        r = '0;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = mat_apply(a, b[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [7:0] affine_lin_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]};
    endfunction

    function automatic logic [7:0] affine_lin_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]};
    endfunction

    function automatic mat_t affine_mat(input logic inverse);
        mat_t r;
        logic [7:0] e;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            e = 8'h01 << k;
            r[8*k +: 8] = inverse ? affine_lin_inv(e) : affine_lin_fwd(e);
        end
        return r;
    endfunction

    // Polynomial basis to tower basis: x maps to a tower root g of x^8+x^4+x^3+x+1.
    function automatic mat_t poly_to_tower();
        mat_t r;
        logic [8:0][7:0] pw;
        logic found;
        r = '0;
        found = 1'b0;
        pw = '0;
        for (int c = 1; c < 256; c++) begin
            if (!found) begin
                pw[0] = GF256_ONE;
                for (int k = 1; k < 9; k++) pw[k] = gf256_mul(pw[k-1], 8'(c));
                if ((pw[8] ^ pw[4] ^ pw[3] ^ pw[1] ^ pw[0]) == 8'h00) begin
                    found = 1'b1;
                    for (int k = 0; k < 8; k++) r[8*k +: 8] = pw[k];
                end
            end
        end
        return r;
    endfunction

    function automatic mat_t mat_invert(input mat_t m);
        mat_t r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            for (int x = 1; x < 256; x++) begin
                if (mat_apply(m, 8'(x)) == (8'h01 << j)) r[8*j +: 8] = 8'(x);
            end
        end
        return r;
    endfunction

    localparam mat_t TO_TOWER   = poly_to_tower();
    localparam mat_t FROM_TOWER = mat_invert(TO_TOWER);

    // Forward: y = A(Inv(x)) ^ 0x63, with A folded into the output basis change.
    localparam mat_t FWD_IN  = TO_TOWER;
    localparam mat_t FWD_OUT = mat_compose(affine_mat(1'b0), FROM_TOWER);

`ifdef CANRIGHT_INVERSE_EN
    // Inverse: y = Inv(A^-1(x ^ 0x63)); A^-1 and its constant fold into the input layer.
    localparam mat_t       INV_IN   = mat_compose(TO_TOWER, affine_mat(1'b1));
    localparam logic [7:0] INV_IN_C = mat_apply(INV_IN, AFFINE_C);
    localparam mat_t       INV_OUT  = FROM_TOWER;
`endif

endpackage

// File: rtl/coastalwhite_canright_sbox_if.sv
// Byte-wide user-project pin bundle for the S-box tile.
interface coastalwhite_canright_sbox_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/coastalwhite_canright_sbox_canright_sbox.sv
// Combinational Canright S-box core sharing one tower-field inverter.
// CANRIGHT_INVERSE_EN adds the inverse input/output layers selected by dir.
module canright_sbox
    import coastalwhite_canright_sbox_pkg::*;
(
    input  logic [7:0] data_in,
    input  logic       dir,
    output logic [7:0] data_out
);
    logic [7:0] tower_in;
    logic [7:0] tower_inv;
    logic [7:0] fwd_out;

    assign tower_inv = gf256_inv(tower_in);
    assign fwd_out   = mat_apply(FWD_OUT, tower_inv) ^ AFFINE_C;

`ifdef CANRIGHT_INVERSE_EN
    always_comb begin
        tower_in = mat_apply(FWD_IN, data_in);
        data_out = fwd_out;
        if (!dir) begin
            tower_in = mat_apply(INV_IN, data_in) ^ INV_IN_C;
            data_out = mat_apply(INV_OUT, tower_inv);
        end
    end
`else
    logic unused_dir;
    assign unused_dir = dir;

    always_comb begin
        tower_in = mat_apply(FWD_IN, data_in);
        data_out = fwd_out;
    end
`endif

endmodule

// File: rtl/coastalwhite_canright_sbox.sv
// Tile top: registers the S-box result on the load strobe; bidir pins stay inputs.
// Direction select is honoured only when CANRIGHT_INVERSE_EN is defined.
module coastalwhite_canright_sbox
    import coastalwhite_canright_sbox_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    coastalwhite_canright_sbox_if.slave   bus
);
    logic [7:0] sbox_out;
    logic [7:0] out_reg;
    logic [7:0] out_next;
    logic       load;
    logic       dir;

    assign load = bus.uio_in[CTRL_LOAD_BIT];
    assign dir  = bus.uio_in[CTRL_DIR_BIT];

    canright_sbox u_core (
        .data_in  (bus.ui_in),
        .dir      (dir),
        .data_out (sbox_out)
    );

    always_comb begin
        out_next = out_reg;
        if (load) out_next = sbox_out;
    end

    always_ff @(posedge clk) begin
        if (rst) out_reg <= 8'h00;
        else     out_reg <= out_next;
    end

    assign bus.uo_out  = out_reg;
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.ena, bus.uio_in[7:2]};

endmodule

// File: tb/tb_coastalwhite_canright_sbox.sv
// Self-checking bench: directed steps plus random traffic against a GF(2^8) reference.
module tb_coastalwhite_canright_sbox;
    logic clk = 1'b0;
    logic rst = 1'b1;

    coastalwhite_canright_sbox_if bus();

    coastalwhite_canright_sbox dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [7:0] sbox_tab [256];
    logic [7:0] inv_tab  [256];
    logic [7:0] model;

    // Polynomial-basis multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 1; j < 256; j++) begin
            if (gmul(a, 8'(j)) == 8'h01) r = 8'(j);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] y;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            y[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
        return y;
    endfunction

    function automatic logic [7:0] expected_sub(input logic [7:0] x, input logic [7:0] ctrl);
`ifdef CANRIGHT_INVERSE_EN
        return ctrl[0] ? sbox_tab[x] : inv_tab[x];
`else
        return (ctrl[0] | ~ctrl[0]) ? sbox_tab[x] : 8'h00;
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic cycle(input logic r, input logic [7:0] ui, input logic [7:0] ctrl);
        rst        = r;
        bus.ui_in  = ui;
        bus.uio_in = ctrl;
        @(posedge clk);
        #1;
        $display("txn t=%0t rst=%0b ui_in=%02h uio_in=%02h uo_out=%02h", $time, r, ui, ctrl, bus.uo_out);
    endtask

    initial begin
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h01;
        bus.uio_in = 8'h03;
        for (int i = 0; i < 256; i++) sbox_tab[i] = affine(ginv(8'(i)));
        for (int i = 0; i < 256; i++) inv_tab[sbox_tab[i]] = 8'(i);

        // Reset held with strobe high, then released without strobe.
        cycle(1'b1, 8'h01, 8'h03);
        cycle(1'b1, 8'h01, 8'h03);
        check("reset_uo", {8'h00, bus.uo_out}, 16'h0000);
        check("reset_bidir", {bus.uio_out, bus.uio_oe}, 16'h0000);
        cycle(1'b0, 8'h01, 8'h00);
        check("post_reset_idle", {8'h00, bus.uo_out}, 16'h0000);

        // Forward spot values.
        cycle(1'b0, 8'h00, 8'h03); check("fwd_00", {8'h00, bus.uo_out}, 16'h0063);
        cycle(1'b0, 8'h01, 8'h03); check("fwd_01", {8'h00, bus.uo_out}, 16'h007C);
        cycle(1'b0, 8'h53, 8'h03); check("fwd_53", {8'h00, bus.uo_out}, 16'h00ED);
        cycle(1'b0, 8'hFF, 8'h03); check("fwd_ff", {8'h00, bus.uo_out}, 16'h0016);

        // Hold when the strobe drops.
        cycle(1'b0, 8'h53, 8'h03); check("hold_load", {8'h00, bus.uo_out}, 16'h00ED);
        cycle(1'b0, 8'hFF, 8'h01); check("hold_1", {8'h00, bus.uo_out}, 16'h00ED);
        cycle(1'b0, 8'hFF, 8'h00); check("hold_2", {8'h00, bus.uo_out}, 16'h00ED);

        // Reset wins over a simultaneous strobe.
        cycle(1'b1, 8'h01, 8'h03); check("reset_vs_strobe", {8'h00, bus.uo_out}, 16'h0000);
        model = 8'h00;

        // Forward sweep with idle setup cycle.
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 8'(i), 8'h01);
            check("sweep_hold", {8'h00, bus.uo_out}, {8'h00, model});
            cycle(1'b0, 8'(i), 8'h03);
            model = sbox_tab[i];
            check("sweep_fwd", {8'h00, bus.uo_out}, {8'h00, model});
            check("sweep_bidir", {bus.uio_out, bus.uio_oe}, 16'h0000);
        end

`ifdef CANRIGHT_INVERSE_EN
        cycle(1'b0, 8'h63, 8'h02); check("inv_63", {8'h00, bus.uo_out}, 16'h0000);
        cycle(1'b0, 8'hED, 8'h02); check("inv_ed", {8'h00, bus.uo_out}, 16'h0053);
        cycle(1'b0, 8'h16, 8'h02); check("inv_16", {8'h00, bus.uo_out}, 16'h00FF);
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, sbox_tab[i], 8'h02);
            check("inv_sweep", {8'h00, bus.uo_out}, 16'(i));
        end
`else
        cycle(1'b0, 8'h00, 8'h02); check("dir_ignored_00", {8'h00, bus.uo_out}, 16'h0063);
        cycle(1'b0, 8'h53, 8'h02); check("dir_ignored_53", {8'h00, bus.uo_out}, 16'h00ED);
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 8'(i), 8'h02);
            check("dir_ignored_sweep", {8'h00, bus.uo_out}, {8'h00, sbox_tab[i]});
        end
`endif

        // Random traffic including junk control bits and occasional resets.
        model = bus.uo_out;
        for (int n = 0; n < 400; n++) begin
            logic       r;
            logic [7:0] ui;
            logic [7:0] ctrl;
            r    = ($urandom_range(0, 15) == 0);
            ui   = 8'($urandom);
            ctrl = 8'($urandom);
            cycle(r, ui, ctrl);
            if (r)            model = 8'h00;
            else if (ctrl[1]) model = expected_sub(ui, ctrl);
            check("random", {bus.uio_oe, bus.uo_out}, {8'h00, model});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/coastalwhite_canright_sbox.md
# coastalwhite_canright_sbox

Single-byte AES S-box engine built around Canright's compact composite-field (GF(((2²)²)²)) inversion, wrapped in the standard 8-in/8-out/8-bidir user-project shell. A byte on the dedicated inputs is substituted when a load strobe is high and the result is registered onto the dedicated outputs. Top-level user project of the chip tile; no other blocks attached.

## Interface
- No parameters.
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  tile-selected indication; ignored by logic.
- ui_in  input  8  byte to substitute.
- uio_in  input  8  control: bit 0 = direction (1 forward S-box, 0 inverse S-box), bit 1 = load strobe; bits 7:2 ignored.
- uo_out  output  8  registered substitution result.
- uio_out  output  8  constant 0x00.
- uio_oe  output  8  constant 0x00; all bidirectional pins are inputs.

## Operation
- Core is purely combinational: x = ui_in; forward: y = Affine(Inv(x)), where Inv is GF(2⁸) inversion (AES polynomial 0x11B, Inv(0) = 0) and Affine adds 0x63.
- Inverse direction: y = Inv(AffineInv(x)), AffineInv removing 0x63 then applying inverse linear map.
- Inversion implemented Canright-style: change of basis into normal-basis tower field, GF(2⁴) inversion via GF(2²) ops, change of basis back; affine and basis matrices merged into the input/output linear layers; one shared inverter serves both directions (direction muxes the input and output linear layers).
- Register: on rising clk, if rst: uo_out ← 0x00; else if uio_in[1]: uo_out ← y; else hold.
- uio_in[0] sampled in the same cycle as the strobe.
- Strobe held high for several cycles: register reloads every cycle, tracking ui_in.
- Reset has priority over a simultaneous strobe.

## Timing
- Latency: one clock; result of ui_in/uio_in present at edge N visible on uo_out after edge N.
- Throughput: one byte per clock.
- Combinational path ui_in → uo_out register only; no combinational input-to-output path.
- Reset value: uo_out = 0x00, uio_out = 0x00, uio_oe = 0x00.
- No handshake beyond the level-sensitive strobe; no busy state.

## Configuration
- CANRIGHT_INVERSE_EN defined: inverse S-box available; uio_in[0] selects direction as above.
- Not defined: only forward linear layers synthesized; uio_in[0] ignored; always forward S-box.

## Structure
- Shared package: input/output basis-change matrices (forward and inverse, affine folded in), the 0x63 affine constant, GF(2²)/GF(2⁴) normal-basis constants (scaling factors N, ν).
- One sub-module: canright_sbox — combinational core (data in, direction in, data out); top holds only the register, strobe/reset logic, and constant bidir outputs.

## Test plan
- Reset: rst high two cycles with strobe high → uo_out = 0x00; released → still 0x00 until strobe.
- Forward spot values (uio_in = 0x03): ui_in 0x00 → 0x63, 0x01 → 0x7C, 0x53 → 0xED, 0xFF → 0x16, one cycle after edge.
- Forward sweep: each i in 0..255 presented with uio_in 0x01 then 0x03 → uo_out equals FIPS-197 S-box[i] after next edge; uio_oe and uio_out stay 0x00 throughout.
- Hold: load 0x53 (→ 0xED), drop strobe, change ui_in to 0xFF → uo_out stays 0xED.
- Inverse (macro defined, uio_in = 0x02): 0x63 → 0x00, 0xED → 0x53, 0x16 → 0xFF; full sweep inverse(forward(i)) = i.
- Reset vs strobe same edge with ui_in 0x01 → uo_out = 0x00.
